// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction RAM.
// Bytes arrive on a valid/ready stream and are packed big-endian into 32-bit
// words written at sequential word addresses. The core is held in reset while
// loading. Fetch reads are combinational and return NOP outside the loaded
// range.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to build the running XOR
// checksum of written words; otherwise checksum is tied to zero.
//
// Handshake: a byte moves on a rising clk edge where s_valid && s_ready.
// s_ready is registered and depends on state only (high in LOAD and DRAIN).
// s_valid/s_data/s_last must be held stable while s_valid is high and
// s_ready is low.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              cpu_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_partial,
  output logic              err_overflow,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic              s_ready_q;
  logic [1:0]        lane_q;
  logic [31:0]       buf_q;
  logic [ADDR_W:0]   word_count_q;
  logic              err_partial_q;
  logic              err_overflow_q;
  logic [31:0]       mem [DEPTH];

  logic              xfer;
  logic              full;
  logic              clear;
  logic              load_byte;
  logic              wr_en;
  logic [31:0]       word_nxt;

  // Handshake decode and word assembly; lower lanes of buf_q are always zero,
  // so an early s_last writes a zero-padded word for free.
  always_comb begin
    xfer      = s_valid && s_ready_q;
    full      = (word_count_q == FULL_CNT);
    clear     = start && ((state_q == IDLE) || (state_q == DONE));
    word_nxt  = buf_q | ({24'h0, s_data} << {~lane_q, 3'b000});
    load_byte = (state_q == LOAD) && xfer && !full;
    wr_en     = load_byte && ((lane_q == 2'd3) || s_last);
  end

  // State register; s_ready follows the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == LOAD) || (state_d == DRAIN);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        if (xfer) begin
          if (s_last)    state_d = DONE;
          else if (full) state_d = DRAIN;
        end
      end
      DRAIN: if (xfer && s_last) state_d = DONE;
      DONE:  if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    s_ready      = s_ready_q;
    cpu_rst      = (state_q != DONE);
    load_done    = (state_q == DONE);
    word_count   = word_count_q;
    err_partial  = err_partial_q;
    err_overflow = err_overflow_q;
  end

  // Lane counter, word buffer, word count and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q         <= 2'd0;
      buf_q          <= 32'h0;
      word_count_q   <= '0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else if (clear) begin
      lane_q         <= 2'd0;
      buf_q          <= 32'h0;
      word_count_q   <= '0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else if (load_byte) begin
      if (wr_en) begin
        lane_q       <= 2'd0;
        buf_q        <= 32'h0;
        word_count_q <= word_count_q + 1'b1;
        if (lane_q != 2'd3) err_partial_q <= 1'b1;
      end else begin
        lane_q <= lane_q + 2'd1;
        buf_q  <= word_nxt;
      end
    end else if ((state_q == LOAD) && xfer && full) begin
      err_overflow_q <= 1'b1;
    end
  end

  // Instruction RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_count_q[ADDR_W-1:0]] <= word_nxt;
  end

  // Combinational fetch; words beyond the current load read as NOP.
  always_comb begin
    fetch_instr = 32'h0;
    if ((state_q == DONE) && ({1'b0, fetch_addr} < word_count_q))
      fetch_instr = mem[fetch_addr];
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running XOR of every word written during the current load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       checksum_q <= 32'h0;
    else if (clear) checksum_q <= 32'h0;
    else if (wr_en) checksum_q <= checksum_q ^ word_nxt;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (4-word instance): directed loads from the test plan
// plus randomized loads checked against a byte-list reference model.
module tb_imem_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_instr;
  logic              cpu_rst;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              err_partial;
  logic              err_overflow;
  logic [31:0]       checksum;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] exp_q[$];
  logic        exp_partial;
  logic        exp_overflow;
  logic [31:0] exp_ck;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_partial  (err_partial),
    .err_overflow (err_overflow),
    .checksum     (checksum)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Reference model: big-endian packing of the byte list, zero-padded tail,
  // truncated to DEPTH words; overflow means bytes beyond 4*DEPTH.
  task automatic model_load();
    int n;
    int nw;
    logic [31:0] w;
    n  = stim_q.size();
    nw = (n + 3) / 4;
    if (nw > DEPTH) nw = DEPTH;
    exp_q.delete();
    exp_ck = 32'h0;
    for (int wi = 0; wi < nw; wi++) begin
      w = 32'h0;
      for (int l = 0; l < 4; l++)
        if (wi * 4 + l < n) w[31 - 8*l -: 8] = stim_q[wi * 4 + l];
      exp_q.push_back(w);
      exp_ck = exp_ck ^ w;
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    exp_ck = 32'h0;
`endif
    exp_overflow = (n > 4 * DEPTH);
    exp_partial  = !exp_overflow && ((n % 4) != 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive stim_q; mode 0 = continuous, 1 = valid toggles, 2 = random gaps.
  // s_ready is sampled at the negedge, where it is stable until the next
  // rising edge, so a byte is consumed exactly when valid&&ready is presented.
  task automatic send_stream(input int mode, input bit with_last);
    int idx = 0;
    int guard = 0;
    bit v = 1'b0;
    while (idx < stim_q.size()) begin
      @(negedge clk);
      case (mode)
        0: v = 1'b1;
        1: v = ~v;
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = stim_q[idx];
      s_last  = with_last && (idx == stim_q.size() - 1);
      if (v && s_ready) idx++;
      guard++;
      if (guard > 2000) begin
        chk("stream_timeout", 32'(idx), 32'(stim_q.size()));
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Compare every visible output of a completed load against the model.
  task automatic check_load(input string tag);
    model_load();
    chk({tag, "_word_count"}, 32'(word_count), 32'(exp_q.size()));
    chk({tag, "_load_done"}, 32'(load_done), 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_err_partial"}, 32'(err_partial), 32'(exp_partial));
    chk({tag, "_err_overflow"}, 32'(err_overflow), 32'(exp_overflow));
    chk({tag, "_checksum"}, checksum, exp_ck);
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = ADDR_W'(a);
      #1;
      chk($sformatf("%s_fetch%0d", tag, a), fetch_instr,
          (a < exp_q.size()) ? exp_q[a] : 32'h0);
    end
  endtask

  initial begin
    logic [31:0] lit_ck;
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0;
    fetch_addr = '0;

    // Reset state
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_err_partial", 32'(err_partial), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_checksum", checksum, 32'h0);
    chk("rst_fetch", fetch_instr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Basic load
    pulse_start();
    chk("basic_s_ready_in_load", 32'(s_ready), 32'd1);
    chk("basic_cpu_rst_in_load", 32'(cpu_rst), 32'd1);
    stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(0, 1'b1);
    check_load("basic");
    fetch_addr = 2'd0; #1;
    chk("basic_word0_literal", fetch_instr, 32'h20080005);

    // Partial word
    pulse_start();
    stim_q = '{8'hAA, 8'hBB};
    send_stream(0, 1'b1);
    check_load("partial");
    fetch_addr = 2'd0; #1;
    chk("partial_word0_literal", fetch_instr, 32'hAABB0000);
    chk("partial_flag_literal", 32'(err_partial), 32'd1);

    // Backpressure gaps
    pulse_start();
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_stream(1, 1'b1);
    check_load("gaps");
    fetch_addr = 2'd0; #1;
    chk("gaps_word0_literal", fetch_instr, 32'h01020304);

    // Overflow: 20 bytes into 4 words
    pulse_start();
    stim_q.delete();
    for (int i = 1; i <= 20; i++) stim_q.push_back(8'(i));
    send_stream(2, 1'b1);
    check_load("ovf");
    chk("ovf_flag_literal", 32'(err_overflow), 32'd1);
    fetch_addr = 2'd3; #1;
    chk("ovf_word3_literal", fetch_instr, 32'h0D0E0F10);

    // Reset mid-load after 6 bytes
    pulse_start();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(0, 1'b0);
    chk("midrst_pre_word_count", 32'(word_count), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_word_count", 32'(word_count), 32'd0);
    chk("midrst_load_done", 32'(load_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = ADDR_W'(a);
      #1;
      chk($sformatf("midrst_fetch%0d", a), fetch_instr, 32'h0);
    end

    // Reload and checksum
    pulse_start();
    stim_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    send_stream(2, 1'b1);
    check_load("ck1");
`ifdef IMEM_LOADER_CHECKSUM_EN
    lit_ck = 32'h1D3B5977;
`else
    lit_ck = 32'h0;
`endif
    chk("ck1_literal", checksum, lit_ck);
    pulse_start();
    chk("ck2_cpu_rst_after_start", 32'(cpu_rst), 32'd1);
    chk("ck2_load_done_after_start", 32'(load_done), 32'd0);
    stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_stream(0, 1'b1);
    check_load("ck2");
`ifdef IMEM_LOADER_CHECKSUM_EN
    lit_ck = 32'hFFFFFFFF;
`else
    lit_ck = 32'h0;
`endif
    chk("ck2_literal", checksum, lit_ck);
    fetch_addr = 2'd1; #1;
    chk("ck2_fetch1_stale", fetch_instr, 32'h0);

    // Randomized loads, including lengths that overflow or end mid-word
    for (int it = 0; it < 6; it++) begin
      pulse_start();
      stim_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 22)); i++)
        stim_q.push_back(8'($urandom));
      send_stream(2, 1'b1);
      check_load($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
